// File: rtl/spi_arb_pkg.sv
// Shared types and defaults for the SPI request arbiter: FSM state encoding,
// default sizing, and a one-hot to index helper.
package spi_arb_pkg;

   localparam int N_REQ_DEF       = 4;
   localparam int XFER_CYCLES_DEF = 10;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_PULSE = 3'd2,
      ST_WAIT  = 3'd3,
      ST_DONE  = 3'd4
   } arb_state_e;

   function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
      logic [2:0] idx;
      idx = '0;
      for (int i = 0; i < 8; i++) begin
         if (oh[i]) idx = 3'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: one-hot winner is the first set request
// bit at or after ptr, wrapping around.
module rr_pick #(
   parameter int N  = 4,
   parameter int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  winner,
   output logic          valid
);

   logic [2*N-1:0] rot_req;
   logic [2*N-1:0] win_dbl;
   logic [N-1:0]   first;

   // Rotate so ptr sits at bit 0, isolate the lowest set bit, rotate back.
   assign rot_req = {req, req} >> ptr;
   assign first   = rot_req[N-1:0] & (~rot_req[N-1:0] + 1'b1);
   assign win_dbl = {first, first} << ptr;
   assign winner  = win_dbl[2*N-1:N];
   assign valid   = |req;

endmodule

// File: rtl/spi_request_arbiter.sv
// Round-robin scheduler sharing one SPI master among N_REQ requesters; runs a
// fixed-length transfer window per grant and returns the received byte.
module spi_request_arbiter
   import spi_arb_pkg::*;
#(
   parameter int N_REQ       = N_REQ_DEF,
   parameter int XFER_CYCLES = XFER_CYCLES_DEF
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [N_REQ-1:0]     req,
   input  logic [2*N_REQ-1:0]   req_ss,
   input  logic [8*N_REQ-1:0]   req_data,
   output logic [N_REQ-1:0]     grant,
   output logic [N_REQ-1:0]     done,
   output logic [7:0]           rx_data,
   output logic                 busy,
   output logic                 start,
   output logic [1:0]           slaveSelect,
   output logic [7:0]           masterDataToSend,
   input  logic [7:0]           masterDataReceived
);

   localparam int PW = $clog2(N_REQ);
   localparam int CW = $clog2(XFER_CYCLES + 1);

   arb_state_e       state;
   logic [PW-1:0]    ptr;
   logic [PW-1:0]    owner;
   logic [PW-1:0]    win_idx;
   logic [CW-1:0]    cnt;
   logic [N_REQ-1:0] win_oh;
   logic             win_vld;
   logic [1:0]       ss_arr   [N_REQ];
   logic [7:0]       data_arr [N_REQ];

   for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
      assign ss_arr[g]   = req_ss[2*g+1:2*g];
      assign data_arr[g] = req_data[8*g+7:8*g];
   end

   rr_pick #(.N(N_REQ), .PW(PW)) u_pick (
      .req    (req),
      .ptr    (ptr),
      .winner (win_oh),
      .valid  (win_vld)
   );

   assign win_idx = PW'(onehot_to_idx(8'(win_oh)));

   always_ff @(posedge clk) begin
      if (!reset) begin
         state            <= ST_IDLE;
         ptr              <= '0;
         owner            <= '0;
         cnt              <= '0;
         grant            <= '0;
         rx_data          <= '0;
         slaveSelect      <= '0;
         masterDataToSend <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (win_vld) begin
                  grant            <= win_oh;
                  owner            <= win_idx;
                  slaveSelect      <= ss_arr[win_idx];
                  masterDataToSend <= data_arr[win_idx];
                  // No slave selected: skip the bus entirely and report zero.
                  if (ss_arr[win_idx] == 2'd0) begin
                     rx_data <= 8'h00;
                     state   <= ST_DONE;
                  end else begin
                     state   <= ST_SETUP;
                  end
               end
            end
            ST_SETUP: state <= ST_PULSE;
            ST_PULSE: begin
               cnt   <= '0;
               state <= ST_WAIT;
            end
            ST_WAIT: begin
               // Capture on the last window cycle so rx_data is valid with done.
               if (cnt == CW'(XFER_CYCLES - 1)) begin
                  rx_data <= masterDataReceived;
                  state   <= ST_DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_DONE: begin
               grant <= '0;
               ptr   <= (owner == PW'(N_REQ - 1)) ? '0 : owner + 1'b1;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign busy  = (state != ST_IDLE);
   assign start = (state == ST_PULSE);
   assign done  = (state == ST_DONE) ? grant : '0;

endmodule

// File: tb/tb_spi_request_arbiter.sv
// Bench for spi_request_arbiter: directed scenarios plus randomized transfers
// checked against a queue-free round-robin reference model and a model master.
module tb_spi_request_arbiter;

   localparam int N  = 4;
   localparam int XC = 10;

   logic           clk = 1'b0;
   logic           reset = 1'b0;
   logic [N-1:0]   req = '0;
   logic [1:0]     ss_a   [N];
   logic [7:0]     data_a [N];
   logic [2*N-1:0] req_ss;
   logic [8*N-1:0] req_data;
   logic [N-1:0]   grant, done;
   logic [7:0]     rx_data;
   logic           busy, start;
   logic [1:0]     slaveSelect;
   logic [7:0]     masterDataToSend;
   logic [7:0]     masterDataReceived = 8'h00;

   int         cyc = 0, start_cnt = 0, done_cnt = 0, cd = 0;
   logic [7:0] slave_resp = 8'h00, resp_lat = 8'h00;
   int         n_tests = 0, n_fail = 0, m_ptr = 0;

   spi_request_arbiter #(.N_REQ(N), .XFER_CYCLES(XC)) dut (
      .clk                (clk),
      .reset              (reset),
      .req                (req),
      .req_ss             (req_ss),
      .req_data           (req_data),
      .grant              (grant),
      .done               (done),
      .rx_data            (rx_data),
      .busy               (busy),
      .start              (start),
      .slaveSelect        (slaveSelect),
      .masterDataToSend   (masterDataToSend),
      .masterDataReceived (masterDataReceived)
   );

   always #5 clk = ~clk;

   always_comb begin
      req_ss   = '0;
      req_data = '0;
      for (int i = 0; i < N; i++) begin
         req_ss[2*i +: 2]   = ss_a[i];
         req_data[8*i +: 8] = data_a[i];
      end
   end

   // Model master: junk on the bus until XC cycles after start, then the response.
   always @(posedge clk) begin
      cyc++;
      if (start === 1'b1) start_cnt++;
      if ((|done) === 1'b1) done_cnt++;
      if (start === 1'b1) begin
         masterDataReceived <= ~slave_resp;
         resp_lat           <= slave_resp;
         cd                 <= XC - 1;
      end else if (cd > 0) begin
         cd <= cd - 1;
         if (cd == 1) masterDataReceived <= resp_lat;
      end
   end

   task automatic tick;
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic int pick(input logic [N-1:0] r, input int p);
      for (int k = 0; k < N; k++) begin
         if (((int'(r) >> ((p + k) % N)) & 1) == 1) return (p + k) % N;
      end
      return -1;
   endfunction

   task automatic wait_grant(output int n);
      n = 0;
      while (grant === '0 && n < 40) begin tick(); n++; end
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (done === '0 && n < 40) begin tick(); n++; end
   endtask

   task automatic test_reset;
      int s0;
      reset = 1'b0;
      req   = '1;
      for (int i = 0; i < N; i++) begin ss_a[i] = 2'd1; data_a[i] = 8'hFF; end
      s0 = start_cnt;
      repeat (3) tick();
      n_tests++; if (grant !== '0) begin n_fail++; $display("FAIL reset_grant: got %b want 0", grant); end
      n_tests++; if (done !== '0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
      n_tests++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_rx: got %h want 00", rx_data); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_tests++; if (start !== 1'b0 || start_cnt != s0) begin n_fail++; $display("FAIL reset_start: got %b want 0", start); end
      n_tests++; if (slaveSelect !== 2'd0 || masterDataToSend !== 8'h00) begin
         n_fail++; $display("FAIL reset_master_if: got ss=%0d tx=%h want 0/00", slaveSelect, masterDataToSend);
      end
      req   = '0;
      reset = 1'b1;
      m_ptr = 0;
   endtask

   task automatic test_single;
      int s0;
      tick();
      ss_a[1] = 2'd2; data_a[1] = 8'hA5; slave_resp = 8'h3C; req = 4'b0010;
      s0 = start_cnt;
      tick();
      n_tests++; if (grant !== 4'b0010 || busy !== 1'b1) begin n_fail++; $display("FAIL single_grant_c1: got %b/%b want 0010/1", grant, busy); end
      n_tests++; if (start !== 1'b0) begin n_fail++; $display("FAIL single_setup_start: got %b want 0", start); end
      n_tests++; if (slaveSelect !== 2'd2 || masterDataToSend !== 8'hA5) begin
         n_fail++; $display("FAIL single_master_if: got %0d/%h want 2/a5", slaveSelect, masterDataToSend);
      end
      tick();
      n_tests++; if (start !== 1'b1) begin n_fail++; $display("FAIL single_start_c2: got %b want 1", start); end
      repeat (10) tick();
      n_tests++; if (done !== '0 || start_cnt - s0 != 1) begin
         n_fail++; $display("FAIL single_c12: got done=%b starts=%0d want 0/1", done, start_cnt - s0);
      end
      tick();
      n_tests++; if (done !== 4'b0010 || grant !== 4'b0010) begin n_fail++; $display("FAIL single_done_c13: got %b/%b want 0010", done, grant); end
      n_tests++; if (rx_data !== 8'h3C) begin n_fail++; $display("FAIL single_rx: got %h want 3c", rx_data); end
      req = '0; m_ptr = 2;
      tick();
      n_tests++; if (done !== '0 || busy !== 1'b0 || slaveSelect !== 2'd2) begin
         n_fail++; $display("FAIL single_c14: got done=%b busy=%b ss=%0d want 0/0/2", done, busy, slaveSelect);
      end
   endtask

   task automatic test_round_robin;
      int n, w, prev;
      logic [N-1:0] oh;
      prev = 0;
      for (int i = 0; i < N; i++) begin ss_a[i] = 2'(i % 3 + 1); data_a[i] = 8'(8'h10 + i); end
      req = 4'hF;
      for (int t = 0; t < 8; t++) begin
         slave_resp = 8'($urandom) | 8'h01;
         w  = pick(req, m_ptr);
         oh = N'(1) << w;
         wait_grant(n);
         n_tests++; if (grant !== oh || masterDataToSend !== data_a[w[1:0]]) begin
            n_fail++; $display("FAIL rr_grant_%0d: got %b/%h want %b/%h", t, grant, masterDataToSend, oh, data_a[w[1:0]]);
         end
         wait_done(n);
         n_tests++; if (n != 12 || done !== oh || rx_data !== slave_resp) begin
            n_fail++; $display("FAIL rr_done_%0d: got lat=%0d done=%b rx=%h want 12/%b/%h", t, n, done, rx_data, oh, slave_resp);
         end
         if (t > 0) begin
            n_tests++; if (cyc - prev != XC + 4) begin n_fail++; $display("FAIL rr_period_%0d: got %0d want %0d", t, cyc - prev, XC + 4); end
         end
         prev  = cyc;
         m_ptr = (w + 1) % N;
         if (t == 7) req = 4'b1001;
         tick();
      end
   endtask

   task automatic test_wrap;
      int n, w;
      logic [N-1:0] oh;
      for (int t = 0; t < 2; t++) begin
         slave_resp = 8'($urandom) | 8'h01;
         w  = pick(req, m_ptr);
         oh = N'(1) << w;
         wait_grant(n);
         n_tests++; if (grant !== oh) begin n_fail++; $display("FAIL wrap_grant_%0d: got %b want %b", t, grant, oh); end
         wait_done(n);
         n_tests++; if (n != 12 || done !== oh || rx_data !== slave_resp) begin
            n_fail++; $display("FAIL wrap_done_%0d: got lat=%0d done=%b rx=%h want 12/%b/%h", t, n, done, rx_data, oh, slave_resp);
         end
         m_ptr = (w + 1) % N;
         if (t == 1) req = '0;
         tick();
      end
   endtask

   task automatic test_no_slave;
      int s0;
      ss_a[0] = 2'd0; data_a[0] = 8'h77; req = 4'b0001;
      s0 = start_cnt;
      tick();
      n_tests++; if (done !== 4'b0001 || grant !== 4'b0001 || busy !== 1'b1) begin
         n_fail++; $display("FAIL noslave_done_c1: got done=%b grant=%b busy=%b want 0001/0001/1", done, grant, busy);
      end
      n_tests++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL noslave_rx: got %h want 00", rx_data); end
      req = '0;
      tick();
      n_tests++; if (done !== '0 || busy !== 1'b0) begin n_fail++; $display("FAIL noslave_c2: got %b/%b want 0/0", done, busy); end
      repeat (3) tick();
      n_tests++; if (start_cnt != s0) begin n_fail++; $display("FAIL noslave_start: got %0d pulses want 0", start_cnt - s0); end
      m_ptr = 1;
   endtask

   task automatic test_abort;
      int n, d0;
      ss_a[0] = 2'd1; data_a[0] = 8'h5E; slave_resp = 8'hC3; req = 4'b0001;
      repeat (7) tick();
      d0    = done_cnt;
      reset = 1'b0;
      tick();
      n_tests++; if (grant !== '0 || busy !== 1'b0 || start !== 1'b0 || done !== '0) begin
         n_fail++; $display("FAIL abort_state: got grant=%b busy=%b start=%b done=%b want 0", grant, busy, start, done);
      end
      reset = 1'b1; m_ptr = 0;
      tick();
      n_tests++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL abort_regrant: got %b want 0001", grant); end
      wait_done(n);
      n_tests++; if (n != 12 || done !== 4'b0001 || rx_data !== 8'hC3 || done_cnt - d0 != 0) begin
         n_fail++; $display("FAIL abort_done: got lat=%0d done=%b rx=%h prior=%0d want 12/0001/c3/0", n, done, rx_data, done_cnt - d0);
      end
      req = '0; m_ptr = 1;
      tick();
   endtask

   task automatic test_random;
      int n, w, s0, exp_lat;
      logic [N-1:0] oh;
      logic [7:0]   exp_rx;
      for (int t = 0; t < 24; t++) begin
         for (int i = 0; i < N; i++) begin ss_a[i] = 2'($urandom_range(0, 3)); data_a[i] = 8'($urandom); end
         req        = N'($urandom_range(1, (1 << N) - 1));
         slave_resp = 8'($urandom);
         w       = pick(req, m_ptr);
         oh      = N'(1) << w;
         exp_lat = (ss_a[w[1:0]] == 2'd0) ? 0 : XC + 2;
         exp_rx  = (ss_a[w[1:0]] == 2'd0) ? 8'h00 : slave_resp;
         s0      = start_cnt;
         wait_grant(n);
         n_tests++; if (n != 1 || grant !== oh || slaveSelect !== ss_a[w[1:0]] || masterDataToSend !== data_a[w[1:0]]) begin
            n_fail++; $display("FAIL rand_grant_%0d: got lat=%0d %b/%0d/%h want 1 %b/%0d/%h", t, n, grant, slaveSelect,
                               masterDataToSend, oh, ss_a[w[1:0]], data_a[w[1:0]]);
         end
         wait_done(n);
         n_tests++; if (n != exp_lat || done !== oh || rx_data !== exp_rx || start_cnt - s0 != (exp_lat == 0 ? 0 : 1)) begin
            n_fail++; $display("FAIL rand_done_%0d: got lat=%0d done=%b rx=%h starts=%0d want %0d/%b/%h", t, n, done, rx_data,
                               start_cnt - s0, exp_lat, oh, exp_rx);
         end
         m_ptr = (w + 1) % N;
         req   = '0;
         tick();
      end
   endtask

   initial begin
      for (int i = 0; i < N; i++) begin ss_a[i] = 2'd0; data_a[i] = 8'h00; end
      test_reset();
      test_single();
      test_round_robin();
      test_wrap();
      test_no_slave();
      test_abort();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "timeout");
   end

endmodule
